// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the table registers; training comes from the execute stage.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_npc,
    input  logic             up_valid,
    input  logic [31:0]      up_pc,
    input  logic             up_taken,
    input  logic [31:0]      up_target,
    input  logic             up_mispredict,
    input  logic             flush,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];
    logic [CTR_W-1:0]   ctr_r    [ENTRIES];
    logic [CNT_W-1:0]   lookup_cnt_r;
    logic [CNT_W-1:0]   mispred_cnt_r;

    logic [IDX_W-1:0]   lk_idx_s;
    logic [TAG_W-1:0]   lk_tag_s;
    logic [IDX_W-1:0]   up_idx_s;
    logic [TAG_W-1:0]   up_tag_s;
    logic               up_hit_s;
    logic [CTR_W-1:0]   up_ctr_s;
    logic               unused_pc_bits_s;

    assign lk_idx_s = lk_pc[IDX_W+1:2];
    assign lk_tag_s = lk_pc[31:IDX_W+2];
    assign up_idx_s = up_pc[IDX_W+1:2];
    assign up_tag_s = up_pc[31:IDX_W+2];
    assign unused_pc_bits_s = ^{lk_pc[1:0], up_pc[1:0]};

    // Prediction: reads the pre-update table state, so same-index updates appear next cycle.
    always_comb begin
        pred_hit   = 1'b0;
        pred_taken = 1'b0;
        pred_npc   = lk_pc + 32'd4;
        if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
            pred_hit = 1'b1;
            if (ctr_r[lk_idx_s][CTR_W-1]) begin
                pred_taken = 1'b1;
                pred_npc   = target_r[lk_idx_s];
            end else begin
                pred_taken = 1'b0;
            end
        end else begin
            pred_hit = 1'b0;
        end
    end

    // Training: hit detection and saturating counter step for the resolved branch.
    always_comb begin
        up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        up_ctr_s = ctr_r[up_idx_s];
        if (up_taken) begin
            if (ctr_r[up_idx_s] != CTR_MAX) begin
                up_ctr_s = ctr_r[up_idx_s] + CTR_W'(1);
            end else begin
                up_ctr_s = CTR_MAX;
            end
        end else begin
            if (ctr_r[up_idx_s] != CTR_MIN) begin
                up_ctr_s = ctr_r[up_idx_s] - CTR_W'(1);
            end else begin
                up_ctr_s = CTR_MIN;
            end
        end
    end

    // Table state: reset, flush (wins over training), then hit-update or taken-miss allocation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= '0;
                target_r[i] <= 32'd0;
                ctr_r[i]    <= CTR_WEAK;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else if (up_valid) begin
            if (up_hit_s) begin
                ctr_r[up_idx_s] <= up_ctr_s;
                if (up_taken) begin
                    target_r[up_idx_s] <= up_target;
                end
            end else if (up_taken) begin
                valid_r[up_idx_s]  <= 1'b1;
                tag_r[up_idx_s]    <= up_tag_s;
                target_r[up_idx_s] <= up_target;
                ctr_r[up_idx_s]    <= CTR_WEAK;
            end
        end
    end

    // Performance counters: wrap naturally, untouched by flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lookup_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else begin
            if (lk_valid) begin
                lookup_cnt_r <= lookup_cnt_r + CNT_W'(1);
            end
            if (up_valid && up_mispredict) begin
                mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
            end
        end
    end

    assign lookup_cnt  = lookup_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, CTR_W=2, CNT_W=4).
module tb_branch_target_buffer;

    logic        CLK;
    logic        RST;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_mispredict;
    logic        flush;
    logic [3:0]  lookup_cnt;
    logic [3:0]  mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(
        .ENTRIES (16),
        .CTR_W   (2),
        .CNT_W   (4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .lk_valid      (lk_valid),
        .lk_pc         (lk_pc),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_npc      (pred_npc),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_taken      (up_taken),
        .up_target     (up_target),
        .up_mispredict (up_mispredict),
        .flush         (flush),
        .lookup_cnt    (lookup_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        up_valid  = 1'b1;
        up_pc     = pc;
        up_taken  = tk;
        up_target = tgt;
        tick();
        up_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] npc);
        lk_pc = pc;
        #1;
        chk({tag, "_hit"},   {31'd0, pred_hit},   {31'd0, hit});
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, "_npc"},   pred_npc,            npc);
    endtask

    // Directed sequence.
    initial begin
        RST = 1'b1; lk_valid = 1'b0; lk_pc = 32'h40;
        up_valid = 1'b0; up_pc = 32'd0; up_taken = 1'b0; up_target = 32'd0;
        up_mispredict = 1'b0; flush = 1'b0;
        tick();
        tick();

        // 1: reset state
        look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
        chk("rst_lookup_cnt",  {28'd0, lookup_cnt},  32'd0);
        chk("rst_mispred_cnt", {28'd0, mispred_cnt}, 32'd0);
        RST = 1'b0;
        tick();

        // 2: allocation, read-old during the update cycle
        up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_target = 32'h100;
        look("readold", 32'h40, 1'b0, 1'b0, 32'h44);
        tick();
        up_valid = 1'b0;
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

        // 3: saturation at 3, then decrement to 0 and hold
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        look("nt1", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        look("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100);
        look("floor", 32'h40, 1'b1, 1'b0, 32'h44);

        // 4: alias overwrite and not-taken miss; qualified mispredict only
        upd(32'h40, 1'b1, 32'h100);
        up_mispredict = 1'b1;
        upd(32'h440, 1'b1, 32'h200);
        up_mispredict = 1'b0;
        look("alias_old", 32'h40,  1'b0, 1'b0, 32'h44);
        look("alias_new", 32'h440, 1'b1, 1'b1, 32'h200);
        upd(32'h1000C, 1'b0, 32'h500);
        look("nt_miss", 32'h1000C, 1'b0, 1'b0, 32'h10010);
        chk("misp_qual_inc", {28'd0, mispred_cnt}, 32'd1);
        up_mispredict = 1'b1;
        tick();
        up_mispredict = 1'b0;
        chk("misp_unqual", {28'd0, mispred_cnt}, 32'd1);
        look("wrap", 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0);

        // 5: flush beats update, mispredict still counted
        upd(32'h40, 1'b1, 32'h100);
        look("pre_flush", 32'h40, 1'b1, 1'b1, 32'h100);
        flush = 1'b1; up_mispredict = 1'b1;
        upd(32'h80, 1'b1, 32'h300);
        flush = 1'b0; up_mispredict = 1'b0;
        look("flush_40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("flush_80", 32'h80, 1'b0, 1'b0, 32'h84);
        chk("flush_misp", {28'd0, mispred_cnt}, 32'd2);
        chk("lookup_idle", {28'd0, lookup_cnt}, 32'd0);

        // 6: lookup counter wrap, then reset mid-burst
        upd(32'h40, 1'b1, 32'h100);
        lk_valid = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("lookup_wrap", {28'd0, lookup_cnt}, 32'd1);
        RST = 1'b1; up_valid = 1'b1; up_pc = 32'h80; up_taken = 1'b1;
        up_target = 32'h300; up_mispredict = 1'b1;
        tick();
        RST = 1'b0; up_valid = 1'b0; up_mispredict = 1'b0; lk_valid = 1'b0;
        look("rst2_40", 32'h40, 1'b0, 1'b0, 32'h44);
        look("rst2_80", 32'h80, 1'b0, 1'b0, 32'h84);
        chk("rst2_lookup",  {28'd0, lookup_cnt},  32'd0);
        chk("rst2_mispred", {28'd0, mispred_cnt}, 32'd0);

        // Counter back at weakly-taken after reset: one not-taken hit drops to not-taken.
        upd(32'h40, 1'b1, 32'h100);
        look("rst2_weak", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0);
        look("rst2_weak_nt", 32'h40, 1'b1, 1'b0, 32'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
